// File: rtl/multiexp_pkg.sv
// Shared types for the multiexp pair dispatcher: pair layout, FSM states and default widths.
package multiexp_pkg;

    localparam int unsigned SCL_BITS_DEF = 256;
    localparam int unsigned PNT_BITS_DEF = 512;

    typedef struct packed {
        logic [SCL_BITS_DEF-1:0] scalar;
        logic [PNT_BITS_DEF-1:0] point;
    } pair_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_t;

endpackage

// File: rtl/if_axi_stream.sv
// Minimal valid/ready stream with end-of-packet flag.
interface if_axi_stream #(
    parameter int unsigned DAT_BITS = 8
);
    logic                val;
    logic                rdy;
    logic [DAT_BITS-1:0] dat;
    logic                eop;

    modport sink   (input val, dat, eop, output rdy);
    modport source (output val, dat, eop, input rdy);
endinterface

// File: rtl/pair_join.sv
// Joins scalar and point streams into one pair stream; both inputs are consumed together or not at all.
module pair_join
    import multiexp_pkg::*;
#(
    parameter int unsigned SCL_BITS = SCL_BITS_DEF,
    parameter int unsigned PNT_BITS = PNT_BITS_DEF
) (
    if_axi_stream.sink                   scl_if,
    if_axi_stream.sink                   pnt_if,
    input  logic                         en,
    output logic                         join_val,
    input  logic                         join_rdy,
    output logic [SCL_BITS+PNT_BITS-1:0] join_dat,
    output logic                         join_eop,
    output logic                         eop_mismatch
);

    always_comb begin
        join_val     = en & scl_if.val & pnt_if.val;
        scl_if.rdy   = join_val & join_rdy;
        pnt_if.rdy   = join_val & join_rdy;
        join_dat     = {scl_if.dat, pnt_if.dat};
        join_eop     = scl_if.eop | pnt_if.eop;
        eop_mismatch = scl_if.eop ^ pnt_if.eop;
    end

endmodule

// File: rtl/multiexp_pair_dispatcher.sv
// Pairs scalars with points and deals them round-robin to NUM_CORES multiexp cores via a one-entry output register.
module multiexp_pair_dispatcher
    import multiexp_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned SCL_BITS  = SCL_BITS_DEF,
    parameter int unsigned PNT_BITS  = PNT_BITS_DEF,
    parameter int unsigned CNT_BITS  = 64
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [CNT_BITS-1:0]          i_num_in,
    if_axi_stream.sink                   i_scl_if,
    if_axi_stream.sink                   i_pnt_if,
    output logic [NUM_CORES-1:0]         o_pair_val,
    input  logic [NUM_CORES-1:0]         i_pair_rdy,
    output logic [SCL_BITS+PNT_BITS-1:0] o_pair_dat,
    output logic                         o_pair_eop,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err
);

    localparam int unsigned PTR_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned DAT_BITS = SCL_BITS + PNT_BITS;
    localparam logic [CNT_BITS-1:0] NUM_CORES_C = CNT_BITS'(NUM_CORES);
    localparam logic [PTR_BITS-1:0] PTR_LAST    = PTR_BITS'(NUM_CORES - 1);

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   num_q, issue_cnt_q, eop_from;
    logic [PTR_BITS-1:0]   ptr_q, tgt_q;
    logic                  out_val_q, out_eop_q, err_q;
    logic [DAT_BITS-1:0]   out_dat_q;

    logic                  run_en, join_val, join_rdy, join_eop, eop_mismatch;
    logic [DAT_BITS-1:0]   join_dat;
    logic                  fire, take, last_pair, start_ok, frame_bad;

    pair_join #(
        .SCL_BITS (SCL_BITS),
        .PNT_BITS (PNT_BITS)
    ) u_pair_join (
        .scl_if       (i_scl_if),
        .pnt_if       (i_pnt_if),
        .en           (run_en),
        .join_val     (join_val),
        .join_rdy     (join_rdy),
        .join_dat     (join_dat),
        .join_eop     (join_eop),
        .eop_mismatch (eop_mismatch)
    );

    always_comb begin
        run_en    = (state_q == StRun);
        fire      = out_val_q & i_pair_rdy[tgt_q];
        join_rdy  = ~out_val_q | fire;
        take      = join_val & join_rdy;
        start_ok  = (state_q == StIdle) & i_start;
        last_pair = (issue_cnt_q == num_q - 1'b1);
        // Pairs at or beyond num - min(num, NUM_CORES) are the final pair of their core.
        eop_from  = (num_q > NUM_CORES_C) ? (num_q - NUM_CORES_C) : '0;
        frame_bad = eop_mismatch | (join_eop != last_pair);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (i_start) state_d = (i_num_in == '0) ? StDone : StRun;
            StRun:   if (take && last_pair) state_d = StDrain;
            StDrain: if (!out_val_q || fire) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            num_q       <= '0;
            issue_cnt_q <= '0;
            ptr_q       <= '0;
            err_q       <= 1'b0;
            out_val_q   <= 1'b0;
            tgt_q       <= '0;
            out_dat_q   <= '0;
            out_eop_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                num_q       <= i_num_in;
                issue_cnt_q <= '0;
                ptr_q       <= '0;
                err_q       <= 1'b0;
            end else if (take) begin
                issue_cnt_q <= issue_cnt_q + 1'b1;
                ptr_q       <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
                if (frame_bad) err_q <= 1'b1;
            end
            if (take) begin
                out_val_q <= 1'b1;
                tgt_q     <= ptr_q;
                out_dat_q <= join_dat;
                out_eop_q <= (issue_cnt_q >= eop_from);
            end else if (fire) begin
                out_val_q <= 1'b0;
            end
        end
    end

    always_comb begin
        o_pair_val = '0;
        if (out_val_q) o_pair_val[tgt_q] = 1'b1;
        o_pair_dat = out_dat_q;
        o_pair_eop = out_eop_q;
        o_busy     = (state_q != StIdle);
        o_done     = (state_q == StDone);
        o_err      = err_q;
    end

endmodule
